status_tx: RTL and testbench

Status packet transmitter for the scanner's PC link. It snapshots scanner state (enable, AFE gain/offset, motor flags, line count) and emits a framed, checksummed status packet into the FT232H TX FIFO write port. It is the device-to-PC counterpart of the command path that parses PC-to-device bytes from the RX FIFO. A top-level mux shares the TX FIFO port with the pixel data formatter: `tx_busy` selects this block, and `bus_grant` indicates that the formatter is idle.

---
 rtl/scanner_pkg.sv | 36 +++
 rtl/status_tx_if.sv | 29 ++
 rtl/status_tx.sv | 163 ++++++++++++++++
 tb/tb_status_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
`default_nettype none
// ============================================================================
// scanner_pkg : shared constants, types and helpers for the scanner PC link
// Rev 1.0
// ============================================================================
package scanner_pkg;

   localparam logic [7:0] STATUS_TYPE        = 8'h01;
   localparam logic [7:0] STATUS_LEN         = 8'h08;
   localparam int         STATUS_FRAME_BYTES = 12;

   localparam int FLAG_EN   = 0;
   localparam int FLAG_HOME = 1;
   localparam int FLAG_FLT  = 2;
   localparam int FLAG_DROP = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } status_tx_state_t;

   // Checksum covers TYPE through line_lo; SYNC is deliberately excluded.
   function automatic logic [7:0] status_chk(
      input logic [7:0]  flags,
      input logic [7:0]  seq,
      input logic [15:0] gain,
      input logic [15:0] off,
      input logic [15:0] line
   );
      return STATUS_TYPE ^ STATUS_LEN ^ flags ^ seq ^
             gain[15:8] ^ gain[7:0] ^ off[15:8] ^ off[7:0] ^
             line[15:8] ^ line[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/status_tx_if.sv
`default_nettype none
// ============================================================================
// status_tx_if : TX FIFO write port shared through the top-level mux
// Rev 1.0
// ============================================================================
interface status_tx_if;
   logic       bus_grant;
   logic       tx_full;
   logic       tx_wrreq;
   logic [7:0] tx_data;
   logic       tx_busy;

   modport master (
      input  bus_grant,
      input  tx_full,
      output tx_wrreq,
      output tx_data,
      output tx_busy
   );

   modport slave (
      output bus_grant,
      output tx_full,
      input  tx_wrreq,
      input  tx_data,
      input  tx_busy
   );
endinterface
`default_nettype wire

// File: rtl/status_tx.sv
`default_nettype none
// ============================================================================
// status_tx : snapshots scanner state and emits a framed, checksummed packet
// Rev 1.0
// ============================================================================
module status_tx
   import scanner_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter int unsigned PERIOD_CYCLES = 10_000_000
) (
   input  wire logic        clk_100M,
   input  wire logic        rst,
   input  wire logic        send_req,
   input  wire logic        cont_en,
   input  wire logic [15:0] cont_gain,
   input  wire logic [15:0] cont_off,
   input  wire logic [15:0] line_count,
   input  wire logic        mtr_nhome,
   input  wire logic        mtr_nflt,
   status_tx_if.master      tx
);

   localparam logic [3:0] c_LAST_IDX = 4'(STATUS_FRAME_BYTES - 1);

   status_tx_state_t state_q;
   logic             pending_q;
   logic             pending_d;
   logic             dropped_q;
   logic             late_drop_q;
   logic [7:0]       seq_q;
   logic [3:0]       idx_q;
   logic [7:0]       tx_data_q;
   logic             nflt_q;
   logic [7:0]       flags_q;
   logic [15:0]      gain_q;
   logic [15:0]      off_q;
   logic [15:0]      line_q;
   logic [7:0]       chk_q;

   logic             w_tick;
   logic             w_trig;
   logic             w_start;
   logic             w_drop;
   logic             w_wr;
   logic [3:0]       w_next_idx;
   logic [7:0]       w_next_byte;
   logic [7:0]       w_flags;

   if (PERIOD_CYCLES > 0) begin : g_timer
      localparam logic [31:0] c_TIMER_LAST = 32'(PERIOD_CYCLES - 1);
      logic [31:0] timer_q;

      always_ff @(posedge clk_100M or posedge rst) begin
         if (rst) begin
            timer_q <= '0;
         end else if (timer_q == c_TIMER_LAST) begin
            timer_q <= '0;
         end else begin
            timer_q <= timer_q + 32'd1;
         end
      end

      assign w_tick = (timer_q == c_TIMER_LAST);
   end else begin : g_no_timer
      assign w_tick = 1'b0;
   end

   // All trigger sources collapse into one request per cycle.
   assign w_trig    = send_req | w_tick | (nflt_q & ~mtr_nflt);
   assign w_start   = (state_q == IDLE) & pending_q;
   assign w_drop    = w_trig & pending_q & ~w_start;
   assign pending_d = w_trig | (pending_q & ~w_start);
   assign w_wr      = (state_q == SEND) & tx.bus_grant & ~tx.tx_full;

   always_comb begin
      w_flags            = 8'h00;
      w_flags[FLAG_EN]   = cont_en;
      w_flags[FLAG_HOME] = ~mtr_nhome;
      w_flags[FLAG_FLT]  = ~mtr_nflt;
      w_flags[FLAG_DROP] = dropped_q;
   end

   assign w_next_idx = idx_q + 4'd1;

   always_comb begin
      w_next_byte = 8'h00;
      case (w_next_idx)
         4'd0:    w_next_byte = SYNC_BYTE;
         4'd1:    w_next_byte = STATUS_TYPE;
         4'd2:    w_next_byte = STATUS_LEN;
         4'd3:    w_next_byte = flags_q;
         4'd4:    w_next_byte = seq_q;
         4'd5:    w_next_byte = gain_q[15:8];
         4'd6:    w_next_byte = gain_q[7:0];
         4'd7:    w_next_byte = off_q[15:8];
         4'd8:    w_next_byte = off_q[7:0];
         4'd9:    w_next_byte = line_q[15:8];
         4'd10:   w_next_byte = line_q[7:0];
         4'd11:   w_next_byte = chk_q;
         default: w_next_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk_100M or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pending_q   <= 1'b0;
         dropped_q   <= 1'b0;
         late_drop_q <= 1'b0;
         seq_q       <= 8'h00;
         idx_q       <= 4'd0;
         tx_data_q   <= 8'h00;
         nflt_q      <= 1'b1;
         flags_q     <= 8'h00;
         gain_q      <= 16'h0000;
         off_q       <= 16'h0000;
         line_q      <= 16'h0000;
         chk_q       <= 8'h00;
      end else begin
         nflt_q    <= mtr_nflt;
         pending_q <= pending_d;
         case (state_q)
            IDLE: begin
               if (pending_q) begin
                  state_q   <= SEND;
                  idx_q     <= 4'd0;
                  tx_data_q <= SYNC_BYTE;
                  flags_q   <= w_flags;
                  gain_q    <= cont_gain;
                  off_q     <= cont_off;
                  line_q    <= line_count;
                  chk_q     <= status_chk(w_flags, seq_q, cont_gain, cont_off, line_count);
               end
            end
            SEND: begin
               // dropped_q is being reported by this frame; later drops wait for the next one.
               if (w_drop) begin
                  late_drop_q <= 1'b1;
               end
               if (w_wr) begin
                  if (idx_q == c_LAST_IDX) begin
                     state_q     <= IDLE;
                     seq_q       <= seq_q + 8'd1;
                     dropped_q   <= late_drop_q | w_drop;
                     late_drop_q <= 1'b0;
                  end else begin
                     idx_q     <= w_next_idx;
                     tx_data_q <= w_next_byte;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx.tx_wrreq = w_wr;
   assign tx.tx_data  = tx_data_q;
   assign tx.tx_busy  = (state_q == SEND);

endmodule
`default_nettype wire

// File: tb/tb_status_tx.sv
`default_nettype none
// ============================================================================
// tb_status_tx : scoreboard bench for status_tx (request path and periodic path)
// Rev 1.0
// ============================================================================
module tb_status_tx;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, req_a, req_b;
   logic        cont_en, nhome, nflt_a, nflt_b;
   logic [15:0] gain, off, line;
   logic [7:0]  seq_a;
   logic [7:0]  exp_a[$];
   logic [7:0]  exp_b[$];
   logic [7:0]  e_a, e_b;
   int          vectors     = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   status_tx_if ifa ();
   status_tx_if ifb ();

   status_tx #(.SYNC_BYTE(8'hA5), .PERIOD_CYCLES(0)) dut_a (
      .clk_100M(clk), .rst(rst_a), .send_req(req_a), .cont_en(cont_en),
      .cont_gain(gain), .cont_off(off), .line_count(line),
      .mtr_nhome(nhome), .mtr_nflt(nflt_a), .tx(ifa)
   );

   status_tx #(.SYNC_BYTE(8'hA5), .PERIOD_CYCLES(1000)) dut_b (
      .clk_100M(clk), .rst(rst_b), .send_req(req_b), .cont_en(cont_en),
      .cont_gain(gain), .cont_off(off), .line_count(line),
      .mtr_nhome(nhome), .mtr_nflt(nflt_b), .tx(ifb)
   );

   function automatic logic [7:0] model_flags(input logic drop, input logic nflt);
      return {4'b0000, drop, ~nflt, ~nhome, cont_en};
   endfunction

   function automatic logic [95:0] model_frame(input logic [7:0] flags, input logic [7:0] seq);
      logic [7:0] b [12];
      logic [7:0] c;
      b[0] = 8'hA5;  b[1] = 8'h01;  b[2] = 8'h08;  b[3] = flags;
      b[4] = seq;    b[5] = gain[15:8]; b[6] = gain[7:0];
      b[7] = off[15:8]; b[8] = off[7:0]; b[9] = line[15:8]; b[10] = line[7:0];
      c = 8'h00;
      for (int i = 1; i <= 10; i++) c = c ^ b[i];
      b[11] = c;
      for (int i = 0; i < 12; i++) model_frame[95-8*i -: 8] = b[i];
   endfunction

   task automatic push_a(input logic [95:0] f);
      for (int i = 0; i < 12; i++) exp_a.push_back(f[95-8*i -: 8]);
   endtask

   task automatic push_b(input logic [95:0] f);
      for (int i = 0; i < 12; i++) exp_b.push_back(f[95-8*i -: 8]);
   endtask

   // Scoreboard: every written byte is checked against the head of its queue.
   always @(negedge clk) begin
      if (ifa.tx_wrreq === 1'b1) begin
         vectors++;
         if (exp_a.size() == 0) begin
            miscompares++;
            $display("FAIL a_unexpected_byte got %02h required no write", ifa.tx_data);
         end else begin
            e_a = exp_a.pop_front();
            if (ifa.tx_data !== e_a) begin
               miscompares++;
               $display("FAIL a_byte got %02h required %02h", ifa.tx_data, e_a);
            end
         end
      end
      if (ifb.tx_wrreq === 1'b1) begin
         vectors++;
         if (exp_b.size() == 0) begin
            miscompares++;
            $display("FAIL b_unexpected_byte got %02h required no write", ifb.tx_data);
         end else begin
            e_b = exp_b.pop_front();
            if (ifb.tx_data !== e_b) begin
               miscompares++;
               $display("FAIL b_byte got %02h required %02h", ifb.tx_data, e_b);
            end
         end
      end
   end

   task automatic pulse_a();
      @(posedge clk); #1 req_a = 1'b1;
      @(posedge clk); #1 req_a = 1'b0;
   endtask

   task automatic wait_idle_a();
      int t = 0;
      while ((exp_a.size() != 0 || ifa.tx_busy) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (t >= 2000) begin
         miscompares++;
         $display("FAIL a_frame_timeout got %0d bytes outstanding required 0", exp_a.size());
      end
   endtask

   task automatic wait_bytes_a(input int want);
      int n = 0;
      int t = 0;
      while (n < want && t < 200) begin
         @(negedge clk);
         if (ifa.tx_wrreq) n++;
         t++;
      end
      vectors++;
      if (n < want) begin
         miscompares++;
         $display("FAIL a_byte_wait got %0d bytes required %0d", n, want);
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
      cont_en = 1'b1; nhome = 1'b0; nflt_a = 1'b1; nflt_b = 1'b1;
      gain = 16'h0; off = 16'h0; line = 16'h0; seq_a = 8'h00;
      ifa.bus_grant = 1'b1; ifa.tx_full = 1'b0;
      ifb.bus_grant = 1'b1; ifb.tx_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors += 3;
      if (ifa.tx_wrreq !== 1'b0) begin miscompares++; $display("FAIL reset_wrreq got %b required 0", ifa.tx_wrreq); end
      if (ifa.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %02h required 00", ifa.tx_data); end
      if (ifa.tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b required 0", ifa.tx_busy); end
      @(posedge clk); #1 rst_a = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (ifa.tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy got %b required 0", ifa.tx_busy); end
   endtask

   task automatic test_single();
      logic [95:0] lit;
      gain = 16'h1234; off = 16'h0056; line = 16'h0102;
      lit = 96'hA5_01_08_03_00_12_34_00_56_01_02_79;
      push_a(lit);
      seq_a = seq_a + 8'd1;
      pulse_a();
      @(negedge clk);
      vectors++;
      if (ifa.tx_wrreq !== 1'b0) begin miscompares++; $display("FAIL single_early got %b required 0", ifa.tx_wrreq); end
      @(negedge clk);
      vectors += 2;
      if (ifa.tx_wrreq !== 1'b1) begin miscompares++; $display("FAIL single_first got %b required 1", ifa.tx_wrreq); end
      if (ifa.tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b required 1", ifa.tx_busy); end
      for (int i = 1; i < 12; i++) begin
         @(negedge clk);
         vectors++;
         if (ifa.tx_wrreq !== 1'b1) begin miscompares++; $display("FAIL single_consecutive byte %0d got %b required 1", i, ifa.tx_wrreq); end
      end
      @(negedge clk);
      vectors += 2;
      if (ifa.tx_wrreq !== 1'b0) begin miscompares++; $display("FAIL single_end_wrreq got %b required 0", ifa.tx_wrreq); end
      if (ifa.tx_busy !== 1'b0) begin miscompares++; $display("FAIL single_end_busy got %b required 0", ifa.tx_busy); end
      wait_idle_a();
   endtask

   task automatic test_backpressure();
      gain = 16'hA55A; off = 16'h8001; line = 16'h7FFE;
      push_a(model_frame(model_flags(1'b0, nflt_a), seq_a));
      seq_a = seq_a + 8'd1;
      pulse_a();
      wait_bytes_a(4);
      @(posedge clk); #1 ifa.tx_full = 1'b1;
      gain = 16'h0000; off = 16'hFFFF; line = 16'h1111;
      repeat (5) begin
         @(negedge clk);
         vectors += 2;
         if (ifa.tx_wrreq !== 1'b0) begin miscompares++; $display("FAIL bp_wrreq got %b required 0", ifa.tx_wrreq); end
         if (ifa.tx_busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy got %b required 1", ifa.tx_busy); end
      end
      @(posedge clk); #1 ifa.tx_full = 1'b0;
      wait_idle_a();
   endtask

   task automatic test_grant_loss();
      gain = 16'hBEEF; off = 16'hCAFE; line = 16'h0FF0;
      push_a(model_frame(model_flags(1'b0, nflt_a), seq_a));
      seq_a = seq_a + 8'd1;
      pulse_a();
      wait_bytes_a(3);
      @(posedge clk); #1 ifa.bus_grant = 1'b0;
      repeat (10) begin
         @(negedge clk);
         vectors++;
         if (ifa.tx_wrreq !== 1'b0) begin miscompares++; $display("FAIL grant_wrreq got %b required 0", ifa.tx_wrreq); end
      end
      @(posedge clk); #1 ifa.bus_grant = 1'b1;
      wait_idle_a();
   endtask

   task automatic test_back_to_back();
      int n   = 0;
      int cyc = 0;
      gain = 16'h2468; off = 16'h1357; line = 16'h0042;
      push_a(model_frame(model_flags(1'b0, nflt_a), seq_a));
      push_a(model_frame(model_flags(1'b1, nflt_a), seq_a + 8'd1));
      seq_a = seq_a + 8'd2;
      while (n < 12 && cyc < 200) begin
         @(posedge clk);
         #1 req_a = (cyc == 0) || (cyc == 4) || (cyc == 6) || (cyc == 8);
         @(negedge clk);
         if (ifa.tx_wrreq) n++;
         cyc++;
      end
      @(negedge clk);
      vectors += 2;
      if (ifa.tx_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_busy got %b required 0", ifa.tx_busy); end
      if (ifa.tx_wrreq !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_wrreq got %b required 0", ifa.tx_wrreq); end
      @(negedge clk);
      vectors++;
      if (ifa.tx_wrreq !== 1'b1) begin miscompares++; $display("FAIL b2b_second_start got %b required 1", ifa.tx_wrreq); end
      wait_idle_a();
      push_a(model_frame(model_flags(1'b0, nflt_a), seq_a));
      seq_a = seq_a + 8'd1;
      pulse_a();
      wait_idle_a();
   endtask

   task automatic test_seq_wrap();
      for (int k = 0; k < 252; k++) begin
         gain = 16'($urandom); off = 16'($urandom); line = 16'($urandom);
         cont_en = k[0]; nhome = k[1];
         push_a(model_frame(model_flags(1'b0, nflt_a), seq_a));
         seq_a = seq_a + 8'd1;
         pulse_a();
         wait_idle_a();
      end
      cont_en = 1'b1; nhome = 1'b0;
   endtask

   task automatic test_reset_midframe();
      gain = 16'h5A5A; off = 16'h0F0F; line = 16'h3C3C;
      push_a(model_frame(model_flags(1'b0, nflt_a), seq_a));
      pulse_a();
      wait_bytes_a(6);
      @(posedge clk); #1 rst_a = 1'b1;
      #1;
      vectors += 2;
      if (ifa.tx_wrreq !== 1'b0) begin miscompares++; $display("FAIL rst_mid_wrreq got %b required 0", ifa.tx_wrreq); end
      if (ifa.tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b required 0", ifa.tx_busy); end
      exp_a.delete();
      seq_a = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0;
      @(negedge clk);
      vectors++;
      if (ifa.tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_mid_data got %02h required 00", ifa.tx_data); end
      push_a(model_frame(model_flags(1'b0, nflt_a), seq_a));
      seq_a = seq_a + 8'd1;
      pulse_a();
      wait_idle_a();
   endtask

   task automatic test_fault_periodic();
      int   starts [4];
      int   k = 0;
      int   t = 0;
      logic prev = 1'b0;
      gain = 16'hC0DE; off = 16'h1001; line = 16'h0200;
      for (int s = 0; s < 4; s++) push_b(model_frame(model_flags(1'b0, 1'b0), 8'(s)));
      @(posedge clk); #1 rst_b = 1'b0;
      repeat (5) @(posedge clk);
      #1 nflt_b = 1'b0;
      while (t < 4000 && !(k >= 4 && exp_b.size() == 0 && !ifb.tx_busy)) begin
         @(negedge clk);
         t++;
         if (ifb.tx_busy && !prev) begin
            if (k < 4) starts[k] = t;
            k++;
         end
         prev = ifb.tx_busy;
      end
      vectors += 4;
      if (k != 4) begin miscompares++; $display("FAIL periodic_frames got %0d required 4", k); end
      if (k >= 2 && (starts[0] > 10 || starts[1] < starts[0] + 900)) begin
         miscompares++; $display("FAIL fault_before_wrap got starts %0d,%0d required fault frame first", starts[0], starts[1]);
      end
      if (k >= 3 && starts[2] - starts[1] != 1000) begin miscompares++; $display("FAIL periodic_interval1 got %0d required 1000", starts[2] - starts[1]); end
      if (k >= 4 && starts[3] - starts[2] != 1000) begin miscompares++; $display("FAIL periodic_interval2 got %0d required 1000", starts[3] - starts[2]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_grant_loss();
      test_back_to_back();
      test_seq_wrap();
      test_reset_midframe();
      test_fault_periodic();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
